// File: rtl/rdm_h2c_write_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : rdm_h2c_write_engine_if
//  Description : H2C stream, DDR4 AXI4 write channel and status stream bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface rdm_h2c_write_engine_if #(
    parameter int ADDR_W = 48
);
    logic              user_lnk_up;
    logic [63:0]       s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [63:0]       m_axi_wdata;
    logic [7:0]        m_axi_wstrb;
    logic              m_axi_wlast;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [63:0]       m_axis_sts_tdata;
    logic              m_axis_sts_tvalid;
    logic              m_axis_sts_tlast;
    logic              m_axis_sts_tready;

    // Engine side
    modport master (
        input  user_lnk_up, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axis_sts_tdata, m_axis_sts_tvalid, m_axis_sts_tlast,
        input  m_axis_sts_tready
    );

    // Host / memory side
    modport slave (
        output user_lnk_up, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axis_sts_tdata, m_axis_sts_tvalid, m_axis_sts_tlast,
        output m_axis_sts_tready
    );
endinterface
`default_nettype wire

// File: rtl/rdm_h2c_write_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rdm_h2c_write_engine
//  Description : Turns host write commands into AXI4 INCR bursts, one status beat each.
//  Revision    : 1.0  initial release
// ============================================================================
module rdm_h2c_write_engine #(
    parameter int ADDR_W    = 48,
    parameter int MAX_BEATS = 256
) (
    input  wire logic              clk,
    input  wire logic              rst,
    rdm_h2c_write_engine_if.master bus
);
    localparam int         c_LEN_W         = $clog2(MAX_BEATS);
    localparam logic [7:0] c_OP_WRITE      = 8'h01;
    localparam logic [7:0] c_STS_TAG       = 8'h81;
    localparam logic [7:0] c_CODE_OK       = 8'h00;
    localparam logic [7:0] c_CODE_BAD_OP   = 8'h01;
    localparam logic [7:0] c_CODE_BAD_ADDR = 8'h02;
    localparam logic [7:0] c_CODE_LEN      = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AW      = 3'd1,
        S_DATA    = 3'd2,
        S_PAD     = 3'd3,
        S_DRAIN_B = 3'd4,
        S_DRAIN   = 3'd5,
        S_BRESP   = 3'd6,
        S_STS     = 3'd7
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [c_LEN_W-1:0]  r_len, w_len_nxt, r_cnt, w_cnt_nxt, w_hdr_len;
    logic [7:0]          r_code, w_code_nxt;
    logic [1:0]          r_bresp, w_bresp_nxt;
    logic [c_LEN_W:0]    w_hdr_beats;
    logic [12:0]         w_hdr_end;
    logic                w_hdr_bad_addr, w_at_last;
    logic                w_s_tready, w_awvalid, w_wvalid, w_wlast, w_bready, w_sts_tvalid;
    logic [63:0]         w_wdata;
    logic [7:0]          w_wstrb;

    // A burst may not cross a 4 KB page: check start offset plus byte count.
    assign w_hdr_len      = bus.s_axis_tdata[48 +: c_LEN_W];
    assign w_hdr_beats    = {1'b0, w_hdr_len} + (c_LEN_W+1)'(1);
    assign w_hdr_end      = 13'(bus.s_axis_tdata[11:0]) + 13'({w_hdr_beats, 3'b000});
    assign w_hdr_bad_addr = (bus.s_axis_tdata[2:0] != 3'b000) || (w_hdr_end > 13'd4096);
    assign w_at_last      = (r_cnt == r_len);

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_len_nxt    = r_len;
        w_cnt_nxt    = r_cnt;
        w_code_nxt   = r_code;
        w_bresp_nxt  = r_bresp;
        w_s_tready   = 1'b0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_wdata      = '0;
        w_wstrb      = '0;
        w_wlast      = 1'b0;
        w_bready     = 1'b0;
        w_sts_tvalid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_s_tready = bus.user_lnk_up & ~rst;
                if (w_s_tready && bus.s_axis_tvalid) begin
                    w_addr_nxt  = bus.s_axis_tdata[ADDR_W-1:0];
                    w_len_nxt   = w_hdr_len;
                    w_cnt_nxt   = '0;
                    w_bresp_nxt = 2'b00;
                    w_code_nxt  = c_CODE_OK;
                    if (bus.s_axis_tlast) begin
                        w_code_nxt  = c_CODE_LEN;
                        w_state_nxt = S_STS;
                    end else if (bus.s_axis_tdata[63:56] != c_OP_WRITE) begin
                        w_code_nxt  = c_CODE_BAD_OP;
                        w_state_nxt = S_DRAIN;
                    end else if (w_hdr_bad_addr) begin
                        w_code_nxt  = c_CODE_BAD_ADDR;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_AW;
                    end
                end
            end
            S_AW: begin
                w_awvalid = 1'b1;
                if (bus.m_axi_awready) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_s_tready = bus.m_axi_wready;
                w_wvalid   = bus.s_axis_tvalid;
                w_wdata    = bus.s_axis_tdata;
                w_wstrb    = 8'hFF;
                w_wlast    = w_at_last;
                if (bus.s_axis_tvalid && bus.m_axi_wready) begin
                    w_cnt_nxt = r_cnt + c_LEN_W'(1);
                    if (w_at_last) begin
                        if (bus.s_axis_tlast) begin
                            w_state_nxt = S_BRESP;
                        end else begin
                            w_code_nxt  = c_CODE_LEN;
                            w_state_nxt = S_DRAIN_B;
                        end
                    end else if (bus.s_axis_tlast) begin
                        w_code_nxt  = c_CODE_LEN;
                        w_state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                // Short payload: finish the announced burst with masked beats.
                w_wvalid = 1'b1;
                w_wlast  = w_at_last;
                if (bus.m_axi_wready) begin
                    w_cnt_nxt = r_cnt + c_LEN_W'(1);
                    if (w_at_last) w_state_nxt = S_BRESP;
                end
            end
            S_DRAIN_B: begin
                w_s_tready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) w_state_nxt = S_BRESP;
            end
            S_DRAIN: begin
                w_s_tready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) w_state_nxt = S_STS;
            end
            S_BRESP: begin
                w_bready = 1'b1;
                if (bus.m_axi_bvalid) begin
                    w_bresp_nxt = bus.m_axi_bresp;
                    w_state_nxt = S_STS;
                end
            end
            S_STS: begin
                w_sts_tvalid = 1'b1;
                if (bus.m_axis_sts_tready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_bresp <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
            r_bresp <= w_bresp_nxt;
        end
    end

    assign bus.s_axis_tready     = w_s_tready;
    assign bus.m_axi_awaddr      = r_addr;
    assign bus.m_axi_awlen       = 8'(r_len);
    assign bus.m_axi_awsize      = 3'b011;
    assign bus.m_axi_awburst     = 2'b01;
    assign bus.m_axi_awvalid     = w_awvalid;
    assign bus.m_axi_wdata       = w_wdata;
    assign bus.m_axi_wstrb       = w_wstrb;
    assign bus.m_axi_wlast       = w_wlast;
    assign bus.m_axi_wvalid      = w_wvalid;
    assign bus.m_axi_bready      = w_bready;
    assign bus.m_axis_sts_tvalid = w_sts_tvalid;
    assign bus.m_axis_sts_tlast  = 1'b1;
    assign bus.m_axis_sts_tdata  = w_sts_tvalid ? {c_STS_TAG, 8'(r_len), r_code, r_bresp, 38'd0} : 64'd0;
endmodule
`default_nettype wire

// File: tb/tb_rdm_h2c_write_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rdm_h2c_write_engine
//  Description : Scoreboard bench: command model predicts AW/W/status traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rdm_h2c_write_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rdm_h2c_write_engine_if #(.ADDR_W(48)) bus ();

    rdm_h2c_write_engine #(.ADDR_W(48), .MAX_BEATS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [55:0] exp_aw[$];
    logic [72:0] exp_w[$];
    logic [63:0] exp_sts[$];
    logic [63:0] pl[0:511];
    bit          sb_on = 1'b0;
    bit          stall = 1'b0;
    bit          hs_b  = 1'b0;
    logic [1:0]  cur_bresp = 2'b00;
    int          b_issued = 0;
    int          b_sent   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got %0h expected no transfer", name, act);
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion", name);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    endtask

    task automatic mon_loop();
        bit          prev_aw = 1'b0;
        bit          prev_sts = 1'b0;
        logic [55:0] ea;
        logic [72:0] ew;
        logic [63:0] es;
        forever begin
            @(negedge clk);
            hs_b = bus.m_axi_bvalid && bus.m_axi_bready;
            if (sb_on && !rst) begin
                if (prev_aw)  check("awvalid_held", bus.m_axi_awvalid, 1);
                if (prev_sts) check("sts_tvalid_held", bus.m_axis_sts_tvalid, 1);
                if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                    if (exp_aw.size() == 0) unexpected("aw", {bus.m_axi_awaddr, bus.m_axi_awlen});
                    else begin
                        ea = exp_aw.pop_front();
                        check("aw_addr_len", {bus.m_axi_awaddr, bus.m_axi_awlen}, ea);
                        check("aw_size_burst", {bus.m_axi_awsize, bus.m_axi_awburst}, {3'b011, 2'b01});
                    end
                end
                if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                    if (bus.m_axi_wlast) b_issued++;
                    if (exp_w.size() == 0) unexpected("w", {bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast});
                    else begin
                        ew = exp_w.pop_front();
                        check("w_data_strb_last", {bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast}, ew);
                    end
                end
                if (bus.m_axis_sts_tvalid && bus.m_axis_sts_tready) begin
                    if (exp_sts.size() == 0) unexpected("sts", bus.m_axis_sts_tdata);
                    else begin
                        es = exp_sts.pop_front();
                        check("sts_word", {bus.m_axis_sts_tlast, bus.m_axis_sts_tdata}, {1'b1, es});
                    end
                end
            end
            prev_aw  = sb_on && !rst && bus.m_axi_awvalid && !bus.m_axi_awready;
            prev_sts = sb_on && !rst && bus.m_axis_sts_tvalid && !bus.m_axis_sts_tready;
        end
    endtask

    // Memory and status sink: random ready stalls, one B per observed wlast.
    task automatic slave_loop();
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.m_axi_awready      = 1'b0;
                bus.m_axi_wready       = 1'b0;
                bus.m_axi_bvalid       = 1'b0;
                bus.m_axis_sts_tready  = 1'b0;
                b_sent                 = b_issued;
            end else begin
                bus.m_axi_awready     = stall ? 1'($urandom % 2) : 1'b1;
                bus.m_axi_wready      = stall ? 1'($urandom % 2) : 1'b1;
                bus.m_axis_sts_tready = stall ? 1'($urandom % 2) : 1'b1;
                if (bus.m_axi_bvalid && hs_b) bus.m_axi_bvalid = 1'b0;
                if (!bus.m_axi_bvalid && (b_sent < b_issued) && (!stall || ($urandom % 2 == 0))) begin
                    bus.m_axi_bvalid = 1'b1;
                    bus.m_axi_bresp  = cur_bresp;
                    b_sent++;
                end
            end
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input bit last);
        int t = 0;
        repeat ($urandom % 3) begin
            @(posedge clk);
            #1;
        end
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        forever begin
            @(negedge clk);
            if (bus.s_axis_tready) break;
            t++;
            if (t > 4000) timeout("h2c_beat_accept");
        end
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_sts.size() != 0) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 20000) timeout("status_return");
        end
        check("aw_outstanding", exp_aw.size(), 0);
        check("w_outstanding", exp_w.size(), 0);
    endtask

    // Reference: decide the command's fate from its fields, then list the traffic it owes.
    task automatic send_cmd(input logic [7:0] op, input int n, input logic [47:0] addr,
                            input int p, input logic [1:0] br);
        bit         axi;
        logic [7:0] code;
        logic [7:0] lenm1;
        lenm1 = 8'(n - 1);
        axi   = (p > 0) && (op == 8'h01) && (addr[2:0] == 3'b000) &&
                (int'(addr[11:0]) + 8 * n <= 4096);
        if (p == 0)                    code = 8'h03;
        else if (op != 8'h01)          code = 8'h01;
        else if (!axi)                 code = 8'h02;
        else if (p == n)               code = 8'h00;
        else                           code = 8'h03;
        cur_bresp = br;
        for (int i = 0; i < p; i++) pl[i] = {$urandom, $urandom};
        if (axi) begin
            exp_aw.push_back({addr, lenm1});
            for (int i = 0; i < n; i++) begin
                if (i < p) exp_w.push_back({pl[i], 8'hFF, 1'(i == n - 1)});
                else       exp_w.push_back({64'd0, 8'h00, 1'(i == n - 1)});
            end
        end
        exp_sts.push_back({8'h81, lenm1, code, (axi ? br : 2'b00), 38'd0});
        drive_beat({op, lenm1, addr}, p == 0);
        for (int i = 0; i < p; i++) drive_beat(pl[i], i == p - 1);
        wait_done();
    endtask

    initial begin
        bus.user_lnk_up       = 1'b0;
        bus.s_axis_tdata      = '0;
        bus.s_axis_tvalid     = 1'b0;
        bus.s_axis_tlast      = 1'b0;
        bus.m_axi_awready     = 1'b0;
        bus.m_axi_wready      = 1'b0;
        bus.m_axi_bresp       = 2'b00;
        bus.m_axi_bvalid      = 1'b0;
        bus.m_axis_sts_tready = 1'b0;
        fork
            mon_loop();
            slave_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valids", {bus.s_axis_tready, bus.m_axi_awvalid, bus.m_axi_wvalid,
                             bus.m_axi_bready, bus.m_axis_sts_tvalid}, 0);
        check("rst_aw_fields", {bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst},
              {48'd0, 8'd0, 3'b011, 2'b01});
        check("rst_data", {bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast, bus.m_axis_sts_tdata}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.user_lnk_up = 1'b1;
        sb_on = 1'b1;
        @(posedge clk);
        #1;

        stall = 1'b0;
        send_cmd(8'h01, 4, 48'h1000, 4, 2'b00);
        stall = 1'b1;
        send_cmd(8'h01, 256, 48'h0800, 256, 2'b00);
        send_cmd(8'h07, 3, 48'h1000, 3, 2'b00);
        send_cmd(8'h01, 2, 48'h0FF8, 2, 2'b00);
        send_cmd(8'h01, 2, 48'h1004, 2, 2'b00);
        send_cmd(8'h01, 4, 48'h3000, 2, 2'b01);
        send_cmd(8'h01, 2, 48'h4000, 5, 2'b00);
        send_cmd(8'h01, 4, 48'h6000, 0, 2'b00);
        send_cmd(8'h01, 1, 48'h7FF8, 1, 2'b11);

        bus.user_lnk_up = 1'b0;
        fork
            send_cmd(8'h01, 2, 48'h5000, 2, 2'b10);
            begin
                repeat (8) begin
                    @(negedge clk);
                    check("tready_link_down", bus.s_axis_tready, 0);
                end
                @(posedge clk);
                #1;
                bus.user_lnk_up = 1'b1;
            end
        join

        for (int k = 0; k < 25; k++) begin
            logic [7:0]  op;
            logic [47:0] addr;
            int          n;
            int          p;
            stall = 1'($urandom % 2);
            op    = ($urandom % 6 == 0) ? 8'($urandom) : 8'h01;
            n     = 1 + $urandom % 16;
            addr  = {36'h000000001, 12'($urandom)};
            if ($urandom % 4 != 0) addr[2:0] = 3'b000;
            p = n - 2 + int'($urandom % 5);
            if (p < 0) p = 0;
            send_cmd(op, n, addr, p, 2'($urandom));
        end

        // Reset in the middle of a burst, with the H2C side still presenting data.
        stall = 1'b0;
        sb_on = 1'b0;
        drive_beat({8'h01, 8'd15, 48'h2000}, 1'b0);
        for (int i = 0; i < 3; i++) drive_beat({$urandom, $urandom}, 1'b0);
        rst = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_awvalid", bus.m_axi_awvalid, 0);
        check("rst_mid_wvalid", bus.m_axi_wvalid, 0);
        check("rst_mid_sts_tvalid", bus.m_axis_sts_tvalid, 0);
        check("rst_mid_tready", bus.s_axis_tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        exp_aw.delete();
        exp_w.delete();
        exp_sts.delete();
        @(posedge clk);
        #1;
        sb_on = 1'b1;
        send_cmd(8'h01, 8, 48'h2000, 8, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
